// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and FSM states.
package alu_pkg;

  localparam logic [5:0] FUNCT_ADDU  = 6'b001001;
  localparam logic [5:0] FUNCT_SUBU  = 6'b001010;
  localparam logic [5:0] FUNCT_AND   = 6'b010001;
  localparam logic [5:0] FUNCT_OR    = 6'b010010;
  localparam logic [5:0] FUNCT_SLL   = 6'b100001;
  localparam logic [5:0] FUNCT_SRL   = 6'b100010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned iterative shift-add multiplier, one multiplier bit per cycle.
// The first partial product is folded into the start edge so the whole multiply spans WIDTH edges.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic [WIDTH:0]   first_sum;
  logic [WIDTH:0]   step_sum;

  assign first_sum = b[0] ? {1'b0, a} : '0;
  assign step_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

  // NOTE: every register here uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (start) begin
      mcand_q       <= a;
      {hi_q, lo_q}  <= {first_sum, b[WIDTH-1:1]};
      cnt_q         <= CW'(WIDTH - 1);
      done_q        <= 1'b0;
    end else if (cnt_q != '0) begin
      {hi_q, lo_q}  <= {step_sum, lo_q[WIDTH-1:1]};
      cnt_q         <= cnt_q - CW'(1);
      done_q        <= (cnt_q == CW'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy    = (cnt_q != '0);
  assign done    = done_q;
  assign product = {hi_q, lo_q};

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake: single-cycle logic ops plus a WIDTH-cycle multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Src1,
  input  logic [WIDTH-1:0] Src2,
  input  logic [SHW-1:0]   Shamt,
  input  logic [5:0]       Funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             illegal
);

  state_t             state_q, state_d;
  logic               accept;
  logic               is_mul;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_illegal;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (Funct == FUNCT_MULTU);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (Src1),
    .b       (Src2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    case (Funct)
      FUNCT_ADDU:  {alu_carry, alu_res} = {1'b0, Src1} + {1'b0, Src2};
      FUNCT_SUBU: begin
        alu_res   = Src1 - Src2;
        alu_carry = (Src1 < Src2);
      end
      FUNCT_AND:   alu_res = Src1 & Src2;
      FUNCT_OR:    alu_res = Src1 | Src2;
      FUNCT_SLL:   alu_res = Src1 << Shamt;
      FUNCT_SRL:   alu_res = Src1 >> Shamt;
      FUNCT_MULTU: ;
      default:     alu_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_mul ? MUL : DONE;
      MUL:     if (!mul_busy) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result registers load only at completion, so input wiggles mid-operation cannot leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept && !is_mul) begin
      result    <= alu_res;
      result_hi <= '0;
      carry     <= alu_carry;
      zero      <= (alu_res == '0);
      illegal   <= alu_illegal;
    end else if (state_q == MUL && mul_done) begin
      {result_hi, result} <= mul_prod;
      carry               <= 1'b0;
      zero                <= (mul_prod == '0);
      illegal             <= 1'b0;
    end else if (out_valid && out_ready) begin
      zero <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against a plain-arithmetic reference model.
module tb_alu_seq;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  localparam logic [5:0] F_ADDU  = 6'b001001;
  localparam logic [5:0] F_SUBU  = 6'b001010;
  localparam logic [5:0] F_AND   = 6'b010001;
  localparam logic [5:0] F_OR    = 6'b010010;
  localparam logic [5:0] F_SLL   = 6'b100001;
  localparam logic [5:0] F_SRL   = 6'b100010;
  localparam logic [5:0] F_MULTU = 6'b011001;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] Src1 = '0;
  logic [WIDTH-1:0] Src2 = '0;
  logic [SHW-1:0]   Shamt = '0;
  logic [5:0]       Funct = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             zero;
  logic             illegal;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Src1      (Src1),
    .Src2      (Src2),
    .Shamt     (Shamt),
    .Funct     (Funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .zero      (zero),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        c;
    logic        z;
    logic        ill;
    int          lat;
  } exp_t;

  function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh);
    exp_t        e;
    logic [63:0] wide;
    e.lo = '0; e.hi = '0; e.c = 1'b0; e.ill = 1'b0; e.lat = 1;
    case (f)
      F_ADDU:  begin wide = {32'd0, a} + {32'd0, b}; e.lo = wide[31:0]; e.c = wide[32]; end
      F_SUBU:  begin e.lo = a - b; e.c = (a < b); end
      F_AND:   e.lo = a & b;
      F_OR:    e.lo = a | b;
      F_SLL:   e.lo = a << sh;
      F_SRL:   e.lo = a >> sh;
      F_MULTU: begin wide = {32'd0, a} * {32'd0, b}; e.lo = wide[31:0]; e.hi = wide[63:32]; e.lat = WIDTH + 1; end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.lo == '0) && (e.hi == '0);
    return e;
  endfunction

  // Issues one request, counts edges from the accept edge (edge 1) until out_valid, then checks.
  // hold > 0 keeps out_ready low that many extra cycles while a competing request is offered.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input int hold);
    exp_t e;
    int   edges;
    bit   ready_low;
    e = model(f, a, b, sh);
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; Funct = f; Src1 = a; Src2 = b; Shamt = sh;
    @(posedge clk);
    edges = 1;
    #1;
    in_valid = 1'b0;
    Src1 = $urandom; Src2 = $urandom; Shamt = SHW'($urandom); Funct = 6'($urandom);
    ready_low = 1'b1;
    @(negedge clk);
    while (!out_valid && edges < 100) begin
      if (in_ready) ready_low = 1'b0;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_latency"}, 64'(edges), 64'(e.lat));
    check({tag, "_busy_not_ready"}, 64'(ready_low && !in_ready), 64'd1);
    check({tag, "_result"}, 64'(result), 64'(e.lo));
    check({tag, "_result_hi"}, 64'(result_hi), 64'(e.hi));
    check({tag, "_carry"}, 64'(carry), 64'(e.c));
    check({tag, "_zero"}, 64'(zero), 64'(e.z));
    check({tag, "_illegal"}, 64'(illegal), 64'(e.ill));
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; Funct = F_ADDU; Src1 = 32'd3; Src2 = 32'd4;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_hold%0d_valid", tag, k), 64'(out_valid), 64'd1);
      check($sformatf("%s_hold%0d_result", tag, k), 64'(result), 64'(e.lo));
      check($sformatf("%s_hold%0d_in_ready", tag, k), 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_released"}, 64'(out_valid), 64'd0);
  endtask

  logic [5:0] legal_ops [7] = '{F_ADDU, F_SUBU, F_AND, F_OR, F_SLL, F_SRL, F_MULTU};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit no_valid;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'({result_hi, result}), 64'd0);
    check("rst_flags", 64'({carry, zero, illegal}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_release_in_ready", 64'(in_ready), 64'd1);

    run_op("addu_0_10", F_ADDU, 32'd0, 32'd10, 5'd0, 0);
    run_op("addu_carry", F_ADDU, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
    run_op("subu_10_5", F_SUBU, 32'd10, 32'd5, 5'd0, 0);
    run_op("subu_5_10", F_SUBU, 32'd5, 32'd10, 5'd0, 0);
    run_op("and_7_14", F_AND, 32'd7, 32'd14, 5'd0, 0);
    run_op("or_7_14", F_OR, 32'd7, 32'd14, 5'd0, 0);
    run_op("sll_10_5", F_SLL, 32'd10, 32'd100, 5'd5, 0);
    run_op("srl_140_5", F_SRL, 32'h140, 32'd0, 5'd5, 0);
    run_op("mul_max_2", F_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0, 0);
    run_op("mul_zero", F_MULTU, 32'd0, 32'hDEAD_BEEF, 5'd0, 0);
    run_op("illegal", 6'b111111, 32'd9, 32'd9, 5'd0, 0);
    run_op("after_illegal", F_OR, 32'd1, 32'd2, 5'd0, 0);
    out_ready = 1'b0;
    run_op("hold_addu", F_ADDU, 32'd1, 32'd1, 5'd0, 5);
    run_op("after_hold", F_ADDU, 32'd3, 32'd4, 5'd0, 0);

    // Reset in the middle of a multiply must discard it.
    @(negedge clk);
    in_valid = 1'b1; Funct = F_MULTU; Src1 = 32'd1234; Src2 = 32'd5678;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midmul_rst_valid", 64'(out_valid), 64'd0);
    check("midmul_rst_result", 64'({result_hi, result}), 64'd0);
    check("midmul_rst_flags", 64'({carry, zero, illegal}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midmul_release_in_ready", 64'(in_ready), 64'd1);
    no_valid = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) no_valid = 1'b0;
    end
    check("midmul_no_valid_after", 64'(no_valid), 64'd1);

    for (int i = 0; i < 30; i++) begin
      int          sel;
      logic [5:0]  f;
      logic [31:0] a, b;
      sel = $urandom_range(0, 7);
      if (sel < 7) f = legal_ops[sel];
      else begin
        f = 6'($urandom);
        foreach (legal_ops[j]) if (legal_ops[j] == f) f = 6'b000000;
      end
      a = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
      run_op($sformatf("rand%0d", i), f, a, b, 5'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width (even, >= 8).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width.
REQ-003 The block SHALL have port clk, input, 1, meaning single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1, meaning request present.
REQ-006 The block SHALL have port in_ready, output, 1, meaning request accepted this cycle if in_valid.
REQ-007 The block SHALL have ports Src1 and Src2, input, WIDTH, meaning operands.
REQ-008 The block SHALL have port Shamt, input, SHW, meaning shift amount.
REQ-009 The block SHALL have port Funct, input, 6, meaning operation code.
REQ-010 The block SHALL have port out_valid, output, 1, meaning result held and valid.
REQ-011 The block SHALL have port out_ready, input, 1, meaning consumer takes result.
REQ-012 The block SHALL have ports result and result_hi, output, WIDTH each, meaning low and high result words.
REQ-013 The block SHALL have ports carry, zero and illegal, output, 1 each, meaning carry/borrow, result==0, and unknown Funct.

Function
REQ-014 Funct codes SHALL be: addu 001001, subu 001010, AND 010001, OR 010010, sll 100001, srl 100010, multu 011001.
REQ-015 The FSM SHALL have states IDLE, MUL and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept occurs on a clock edge with in_valid and in_ready both 1; operands and Funct are registered at accept.
REQ-017 For non-multu ops, the FSM SHALL go IDLE->DONE at accept, so out_valid rises on the next edge (latency 1).
REQ-018 addu SHALL produce result = Src1+Src2 mod 2^WIDTH, with carry = bit WIDTH of the sum.
REQ-019 subu SHALL produce result = Src1-Src2 mod 2^WIDTH, with carry = 1 when Src1 < Src2 (borrow).
REQ-020 AND/OR SHALL be bitwise; sll/srl SHALL shift Src1 by Shamt, zero-filled, with Src2 ignored; carry SHALL be 0 for these ops.
REQ-021 For all non-multu ops, result_hi SHALL be 0.
REQ-022 multu SHALL be an unsigned iterative shift-add taking exactly WIDTH cycles in MUL, then go to DONE; out_valid rises WIDTH+1 edges after accept; {result_hi,result} = Src1*Src2.
REQ-023 For a multu with an operand of zero, the block SHALL still take the full WIDTH cycles (fixed latency).
REQ-024 An unknown Funct SHALL be accepted, with result=0, result_hi=0, carry=0 and illegal=1, at latency 1.
REQ-025 zero SHALL be 1 when result==0, and also requires result_hi==0 for multu.
REQ-026 In DONE, all outputs SHALL remain stable until out_ready=1, and that edge returns the FSM to IDLE.
REQ-027 Changes to the inputs (Src1, Src2, Shamt, Funct) outside an accept edge SHALL not affect any result in progress or held.

Reset
REQ-028 When rst_n is low, the FSM SHALL go to IDLE immediately, asynchronously.
REQ-029 During reset, out_valid, result, result_hi, carry, zero and illegal SHALL be 0; zero SHALL be 0 while out_valid is 0.
REQ-030 A reset during MUL or DONE SHALL discard the operation, with no out_valid after release.
REQ-031 in_ready SHALL be 1 on the first cycle after rst_n deasserts.

Structure
REQ-032 Package alu_pkg SHALL hold the Funct localparams and the FSM state enum.
REQ-033 Sub-module alu_mul_seq (start, busy, done, operands, 2*WIDTH product) SHALL implement the multiply.
REQ-034 All other ops SHALL be combinational in alu_seq, with outputs registered at the IDLE->DONE transition.

Verification (WIDTH=32, out_ready=1 unless stated)
REQ-035 Directed test: addu Src1=0, Src2=10 -> result=0xA, carry=0, out_valid one cycle after accept; subu 10,5 -> 0x5; subu 5,10 -> 0xFFFFFFFB, carry=1.
REQ-036 Directed test: AND 7,14 -> 0x6; OR 7,14 -> 0xF; sll Src1=10, Shamt=5, Src2=100 -> 0x140; srl Src1=0x140, Shamt=5 -> 0xA.
REQ-037 Directed test: multu 0xFFFFFFFF,2 -> result_hi=0x1, result=0xFFFFFFFE, out_valid exactly 33 edges after accept, in_ready=0 throughout.
REQ-038 Directed test: out_ready held 0 for 5 cycles after addu 1,1 -> result=0x2 stable, in_ready=0, second request not accepted until after release.
REQ-039 Directed test: rst_n pulsed low at cycle 10 of multu -> outputs 0 immediately, no out_valid afterward, in_ready=1 after release.
REQ-040 Directed test: Funct=111111 -> illegal=1, result=0, zero=1, latency 1; next legal op clears illegal.
